// File: rtl/wb_regfile.sv
// Writeback-end register file: selects the writeback value, commits it into a
// 32x32 register file, serves two combinational read ports to ID and counts
// committed writes.
// Optional feature: define WB_REGFILE_BYPASS_EN for write-through read bypass.
module wb_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic        WB_RegWrite,
    input  logic        WB_mem_to_reg,
    input  logic [31:0] WB_C,
    input  logic [31:0] WB_read,
    input  logic [4:0]  WB_writereg_num,
    input  logic [4:0]  ID_rs_num,
    input  logic [4:0]  ID_rt_num,
    output logic [31:0] ID_A,
    output logic [31:0] ID_B,
    output logic [31:0] WB_wdata,
    output logic [31:0] wb_count
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned NREG = 32;
    localparam int unsigned AW   = 5;

    logic [XLEN-1:0] regs [0:NREG-1];
    logic [XLEN-1:0] count;
    logic            commit;

    // Writeback value select and commit qualifier (no commit while in reset or to $0)
    always_comb begin
        WB_wdata = WB_mem_to_reg ? WB_read : WB_C;
        commit   = WB_RegWrite && (WB_writereg_num != AW'(0)) && !rst;
    end

    // Read port A: $0 is hardwired zero; optional bypass of a pending commit
    always_comb begin
        ID_A = '0;
        if (ID_rs_num != AW'(0)) begin
            ID_A = regs[ID_rs_num];
        end
`ifdef WB_REGFILE_BYPASS_EN
        if (commit && (ID_rs_num == WB_writereg_num)) begin
            ID_A = WB_wdata;
        end
`endif
    end

    // Read port B: resolved independently of port A
    always_comb begin
        ID_B = '0;
        if (ID_rt_num != AW'(0)) begin
            ID_B = regs[ID_rt_num];
        end
`ifdef WB_REGFILE_BYPASS_EN
        if (commit && (ID_rt_num == WB_writereg_num)) begin
            ID_B = WB_wdata;
        end
`endif
    end

    // Register array and write counter; async clear, commit on rising edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NREG); i++) begin
                regs[i] <= '0;
            end
            count <= '0;
        end else if (commit) begin
            regs[WB_writereg_num] <= WB_wdata;
            count                 <= count + XLEN'(1);
        end
    end

    assign wb_count = count;

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: stimulus pushes expected outputs, a monitor
// pops and compares them on the falling edge (mid-cycle, before the next commit).
module tb_wb_regfile;

`ifdef WB_REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        WB_RegWrite;
    logic        WB_mem_to_reg;
    logic [31:0] WB_C;
    logic [31:0] WB_read;
    logic [4:0]  WB_writereg_num;
    logic [4:0]  ID_rs_num;
    logic [4:0]  ID_rt_num;
    logic [31:0] ID_A;
    logic [31:0] ID_B;
    logic [31:0] WB_wdata;
    logic [31:0] wb_count;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] wd;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    wb_regfile dut (
        .clk             (clk),
        .rst             (rst),
        .WB_RegWrite     (WB_RegWrite),
        .WB_mem_to_reg   (WB_mem_to_reg),
        .WB_C            (WB_C),
        .WB_read         (WB_read),
        .WB_writereg_num (WB_writereg_num),
        .ID_rs_num       (ID_rs_num),
        .ID_rt_num       (ID_rt_num),
        .ID_A            (ID_A),
        .ID_B            (ID_B),
        .WB_wdata        (WB_wdata),
        .wb_count        (wb_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string name, input string field,
                       input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s.%s: got %08h, expected %08h", name, field, act, req);
        end
    endtask

    // Monitor: checks every queued expectation against outputs at the falling edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                cmp(e.name, "ID_A",     ID_A,     e.a);
                cmp(e.name, "ID_B",     ID_B,     e.b);
                cmp(e.name, "WB_wdata", WB_wdata, e.wd);
                cmp(e.name, "wb_count", wb_count, e.cnt);
            end
        end
    end

    // Advance to just after the next rising edge and drive a new set of inputs
    task automatic go(input logic we, input logic m2r, input logic [31:0] c,
                      input logic [31:0] rd, input logic [4:0] wn,
                      input logic [4:0] rs, input logic [4:0] rt);
        @(posedge clk);
        #1;
        WB_RegWrite     = we;
        WB_mem_to_reg   = m2r;
        WB_C            = c;
        WB_read         = rd;
        WB_writereg_num = wn;
        ID_rs_num       = rs;
        ID_rt_num       = rt;
    endtask

    task automatic expect_out(input string name, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] wd, input logic [31:0] cnt);
        exp_t e;
        e.name = name; e.a = a; e.b = b; e.wd = wd; e.cnt = cnt;
        sb.push_back(e);
    endtask

    initial begin
        rst             = 1'b1;
        WB_RegWrite     = 1'b0;
        WB_mem_to_reg   = 1'b0;
        WB_C            = '0;
        WB_read         = '0;
        WB_writereg_num = '0;
        ID_rs_num       = '0;
        ID_rt_num       = '0;

        // Writes presented during reset are not committed and not bypassed
        go(1'b1, 1'b0, 32'h0000CAFE, 32'h0, 5'd5, 5'd5, 5'd5);
        expect_out("rst_write0", 32'h0, 32'h0, 32'h0000CAFE, 32'h0);
        go(1'b1, 1'b1, 32'h0000CAFE, 32'h0000BEEF, 5'd5, 5'd5, 5'd0);
        expect_out("rst_write1", 32'h0, 32'h0, 32'h0000BEEF, 32'h0);

        // Out of reset: every register reads zero on both ports
        go(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd31);
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            go(1'b0, 1'b0, 32'(i), 32'hFFFFFFFF, 5'(i), 5'(i), 5'(31 - i));
            expect_out($sformatf("zero_r%0d", i), 32'h0, 32'h0, 32'(i), 32'h0);
        end

        // ALU-result writeback to $5
        go(1'b1, 1'b0, 32'h12345678, 32'hFFFF0000, 5'd5, 5'd5, 5'd0);
        expect_out("wr5_same", BYP ? 32'h12345678 : 32'h0, 32'h0, 32'h12345678, 32'h0);
        go(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd0);
        expect_out("rd5", 32'h12345678, 32'h0, 32'h0, 32'h1);

        // Memory-data writeback to $7, then an ignored write to $0
        go(1'b1, 1'b1, 32'h00000001, 32'hDEADBEEF, 5'd7, 5'd7, 5'd5);
        expect_out("wr7_same", BYP ? 32'hDEADBEEF : 32'h0, 32'h12345678, 32'hDEADBEEF, 32'h1);
        go(1'b1, 1'b0, 32'hFFFFFFFF, 32'h0, 5'd0, 5'd7, 5'd0);
        expect_out("wr0_same", 32'hDEADBEEF, 32'h0, 32'hFFFFFFFF, 32'h2);
        go(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd7);
        expect_out("rd0_rd7", 32'h0, 32'hDEADBEEF, 32'h0, 32'h2);

        // Both ports on the register being written in the same cycle
        go(1'b1, 1'b0, 32'hA5A5A5A5, 32'h0, 5'd9, 5'd9, 5'd9);
        expect_out("wr9_same", BYP ? 32'hA5A5A5A5 : 32'h0, BYP ? 32'hA5A5A5A5 : 32'h0,
                   32'hA5A5A5A5, 32'h2);
        go(1'b0, 1'b0, 32'h11111111, 32'h0, 5'd9, 5'd9, 5'd9);
        expect_out("rd9_nowe", 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h11111111, 32'h3);

        // Overwrite $5 while port B reads a different register
        go(1'b1, 1'b0, 32'h0BADF00D, 32'h0, 5'd5, 5'd5, 5'd9);
        expect_out("ovr5_same", BYP ? 32'h0BADF00D : 32'h12345678, 32'hA5A5A5A5,
                   32'h0BADF00D, 32'h3);
        go(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd7);
        expect_out("rd5_rd7", 32'h0BADF00D, 32'hDEADBEEF, 32'h0, 32'h4);

        // Write $3, then async reset mid-cycle clears it immediately
        go(1'b1, 1'b0, 32'h00000055, 32'h0, 5'd3, 5'd3, 5'd5);
        expect_out("wr3_same", BYP ? 32'h55 : 32'h0, 32'h0BADF00D, 32'h55, 32'h4);
        go(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd3, 5'd3);
        expect_out("rd3", 32'h55, 32'h55, 32'h0, 32'h5);
        go(1'b1, 1'b0, 32'h00000077, 32'h0, 5'd3, 5'd3, 5'd3);
        #1;
        rst = 1'b1;
        expect_out("async_rst", 32'h0, 32'h0, 32'h77, 32'h0);
        go(1'b1, 1'b0, 32'h00000077, 32'h0, 5'd3, 5'd3, 5'd3);
        expect_out("rst_edge_drop", 32'h0, 32'h0, 32'h77, 32'h0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        go(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd3, 5'd5);
        expect_out("post_rst_wr3", 32'h77, 32'h0, 32'h0, 32'h1);

        // Counter wrap via backdoor preload
        go(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd9, 5'd0);
        dut.count = 32'hFFFFFFFE;
        expect_out("preload", 32'h0, 32'h0, 32'h0, 32'hFFFFFFFE);
        go(1'b1, 1'b0, 32'h00000001, 32'h0, 5'd10, 5'd10, 5'd0);
        expect_out("wr10_same", BYP ? 32'h1 : 32'h0, 32'h0, 32'h1, 32'hFFFFFFFE);
        go(1'b1, 1'b0, 32'h00000002, 32'h0, 5'd11, 5'd10, 5'd11);
        expect_out("cnt_max", 32'h1, BYP ? 32'h2 : 32'h0, 32'h2, 32'hFFFFFFFF);
        go(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd11, 5'd0);
        expect_out("cnt_wrap", 32'h2, 32'h0, 32'h0, 32'h0);

        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
